xy_switch_alloc: RTL

Per-router switch allocator for the 5-port mesh router. It computes dimension-ordered (XY) routes for the head flit of each of the five input buffers. It arbitrates each output port round-robin among competing inputs and tracks downstream buffer credits per output. It also drives registered crossbar select/valid to the router datapath. One instance sits inside each router, between the input FIFOs and the output crossbar.

---
 rtl/xy_switch_alloc.sv | 135 +++++++++++++
 1 files changed

// File: rtl/xy_switch_alloc.sv
// Switch allocator for a 5-port mesh router: XY route per input head flit,
// round-robin arbitration and credit tracking per output, registered crossbar controls.

module xy_sa_out #(
  parameter logic EN      = 1'b1,
  parameter int   CREDITS = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] req,
  input  logic       credit_ret,
  output logic [4:0] win,
  output logic       xbar_vld,
  output logic [2:0] xbar_sel,
  output logic       cerr_evt
);
  localparam logic [3:0] CMAX = 4'(CREDITS);

  logic [2:0] ptr;
  logic [3:0] credit;
  logic [3:0] sum;
  logic [2:0] idx, win_idx;
  logic       found;

  // rotate the search start by ptr, wrapping modulo 5
  always_comb begin
    found   = 1'b0;
    win_idx = '0;
    sum     = '0;
    idx     = '0;
    if (EN && credit != 4'd0) begin
      for (int k = 0; k < 5; k++) begin
        sum = {1'b0, ptr} + 4'(k);
        idx = (sum >= 4'd5) ? 3'(sum - 4'd5) : sum[2:0];
        if (!found && req[idx]) begin
          found   = 1'b1;
          win_idx = idx;
        end
      end
    end
  end

  assign win      = found ? (5'b00001 << win_idx) : 5'b00000;
  assign cerr_evt = credit_ret && !found && credit == CMAX;

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr      <= '0;
      credit   <= CMAX;
      xbar_vld <= 1'b0;
      xbar_sel <= '0;
    end else begin
      xbar_vld <= found;
      xbar_sel <= win_idx;
      if (found) ptr <= (win_idx == 3'd4) ? 3'd0 : win_idx + 3'd1;
      if (found && !credit_ret)
        credit <= credit - 4'd1;
      else if (!found && credit_ret && credit != CMAX)
        credit <= credit + 4'd1;
    end
  end
endmodule

module xy_switch_alloc #(
  parameter int         X_ID     = 0,
  parameter int         Y_ID     = 0,
  parameter int         COORDW   = 2,
  parameter int         CREDITS  = 4,
  parameter logic [4:0] EN_PORTS = 5'b11111
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [4:0]        req_valid,
  input  logic [5*COORDW-1:0] req_dst_x,
  input  logic [5*COORDW-1:0] req_dst_y,
  output logic [4:0]        gnt,
  output logic [4:0]        xbar_vld,
  output logic [14:0]       xbar_sel,
  input  logic [4:0]        credit_ret,
  output logic              route_err,
  output logic              credit_err
);
  logic [4:0][2:0] route;
  logic [4:0][4:0] req_m;
  logic [4:0][4:0] win_m;
  logic [4:0]      drop, cerr_evt;
  logic [4:0]      gnt_any;

  genvar gp, go;
  generate
    for (gp = 0; gp < 5; gp++) begin : g_in
      logic [COORDW-1:0] dx, dy;
      assign dx = req_dst_x[gp*COORDW +: COORDW];
      assign dy = req_dst_y[gp*COORDW +: COORDW];
      assign route[gp] = (dx > COORDW'(X_ID)) ? 3'd1 :
                         (dx < COORDW'(X_ID)) ? 3'd2 :
                         (dy > COORDW'(Y_ID)) ? 3'd4 :
                         (dy < COORDW'(Y_ID)) ? 3'd3 : 3'd0;
      // flits routed to a missing side are popped and discarded
      assign drop[gp] = req_valid[gp] && !EN_PORTS[route[gp]];
    end

    for (go = 0; go < 5; go++) begin : g_out
      for (gp = 0; gp < 5; gp++) begin : g_req
        assign req_m[go][gp] = req_valid[gp] && route[gp] == 3'(go);
      end
      xy_sa_out #(.EN(EN_PORTS[go]), .CREDITS(CREDITS)) u_out (
        .clk       (clk),
        .rst       (rst),
        .req       (req_m[go]),
        .credit_ret(credit_ret[go]),
        .win       (win_m[go]),
        .xbar_vld  (xbar_vld[go]),
        .xbar_sel  (xbar_sel[3*go +: 3]),
        .cerr_evt  (cerr_evt[go])
      );
    end
  endgenerate

  always_comb begin
    gnt_any = drop;
    for (int o = 0; o < 5; o++) gnt_any = gnt_any | win_m[o];
    gnt = rst ? 5'b00000 : gnt_any;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      route_err  <= 1'b0;
      credit_err <= 1'b0;
    end else begin
      if (|drop)     route_err  <= 1'b1;
      if (|cerr_evt) credit_err <= 1'b1;
    end
  end
endmodule
